mult_share_arbiter: RTL and testbench

- Shares one pipelined signed multiplier (one issue per cycle, fixed latency) among K requesters.
- Round-robin arbitration issues operands to the multiplier and carries a requester tag down a shadow pipeline aligned with the multiplier latency.
- Each result is returned to the requester that issued it.
- Sits between the requester blocks and the multiplier. The multiplier is instantiated outside this block and connected through the MUL_* ports.

---
 rtl/mult_arb_pkg.sv | 53 +++++
 rtl/mult_arb_tagpipe.sv | 52 +++++
 rtl/mult_share_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
//   Shared types and helpers for the multiplier-sharing arbiter.
//   - tag_t   : requester tag carried alongside an operation in flight.
//   - rr_pick : round-robin pick of the first set request at or after a
//               pointer, wrapping inside the first k positions.
//   Tag ids are sized for the largest supported requester count (16) so the
//   same type serves every instance of the arbiter.
// -----------------------------------------------------------------------------
package mult_arb_pkg;

   localparam int MAX_K    = 16;
   localparam int TAG_ID_W = 4;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   localparam tag_t TAG_IDLE = '{valid: 1'b0, id: '0};

   // Returns a one-hot vector selecting the requester with the smallest
   // circular distance from ptr among the set bits of req[k-1:0].
   function automatic logic [MAX_K-1:0] rr_pick(
      input logic [MAX_K-1:0]    req,
      input logic [TAG_ID_W-1:0] ptr,
      input int unsigned         k
   );
      logic [MAX_K-1:0] gnt;
      int               p;
      int               d;
      int               best_d;
      int               best_i;
      gnt    = '0;
      p      = int'(ptr);
      best_d = int'(k);
      best_i = 0;
      for (int i = 0; i < MAX_K; i++) begin
         if ((i < int'(k)) && req[i]) begin
            d = (i >= p) ? (i - p) : (i + int'(k) - p);
            if (d < best_d) begin
               best_d = d;
               best_i = i;
            end
         end
      end
      for (int i = 0; i < MAX_K; i++) begin
         gnt[i] = (best_d < int'(k)) && (i == best_i);
      end
      return gnt;
   endfunction

endpackage

// File: rtl/mult_arb_tagpipe.sv
// -----------------------------------------------------------------------------
// mult_arb_tagpipe
//   LAT-deep shift register of requester tags running in lock-step with the
//   external multiplier pipeline. Every stage shifts every cycle; the last
//   stage lines up with the multiplier's result-valid strobe.
//
//   Ports:
//     CLOCK   in   clock, rising edge
//     RESET   in   asynchronous, active-low reset
//     i_tag   in   tag entering stage 0 (valid only on a grant)
//     o_tag   out  tag in the last stage (stage LAT-1)
//     o_busy  out  any stage holds a valid tag
// -----------------------------------------------------------------------------
module mult_arb_tagpipe
   import mult_arb_pkg::*;
#(
   parameter int LAT = 10
)(
   input  logic CLOCK,
   input  logic RESET,
   input  tag_t i_tag,
   output tag_t o_tag,
   output logic o_busy
);

   tag_t r_stage [LAT];

   // NOTE: every stage is reset, not just the data path: a stale valid bit
   // surviving reset would later be delivered as a phantom result.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         for (int j = 0; j < LAT; j++) begin
            r_stage[j] <= TAG_IDLE;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int j = 1; j < LAT; j++) begin
            r_stage[j] <= r_stage[j-1];
         end
      end
   end

   assign o_tag = r_stage[LAT-1];

   always_comb begin
      o_busy = 1'b0;
      for (int j = 0; j < LAT; j++) begin
         o_busy = o_busy | r_stage[j].valid;
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//   Shares one external pipelined signed multiplier among K requesters.
//   A round-robin arbiter issues one requester's operands per cycle; a tag
//   pipeline of the multiplier's depth remembers who issued each operation so
//   the product can be returned to that requester. Each requester may have at
//   most MAX_OUT operations in flight.
//
//   Ports:
//     CLOCK, RESET       clock (rising edge), async active-low reset
//     ENABLE             permits new grants; in-flight work always drains
//     REQ[K]             per-requester request, held until granted
//     A_IN, B_IN[K*N]    signed operands, requester i at bits [i*N +: N]
//     GNT[K]             combinational one-hot grant
//     MUL_START/A/B      registered issue strobe and operands to multiplier
//     MUL_S, MUL_END     product and result-valid from multiplier
//     RES_VALID[K]       one-cycle one-hot result pulse
//     RES_S[2N]          registered product, held between results
//     IDLE               nothing in flight and no issue this cycle
//     ERR                sticky: MUL_END disagreed with the tag pipeline
// -----------------------------------------------------------------------------
module mult_share_arbiter
   import mult_arb_pkg::*;
#(
   parameter int N       = 8,
   parameter int K       = 4,
   parameter int LAT     = N + 2,
   parameter int MAX_OUT = 4
)(
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic [K-1:0]     REQ,
   input  logic [K*N-1:0]   A_IN,
   input  logic [K*N-1:0]   B_IN,
   output logic [K-1:0]     GNT,
   output logic             MUL_START,
   output logic [N-1:0]     MUL_A,
   output logic [N-1:0]     MUL_B,
   input  logic [2*N-1:0]   MUL_S,
   input  logic             MUL_END,
   output logic [K-1:0]     RES_VALID,
   output logic [2*N-1:0]   RES_S,
   output logic             IDLE,
   output logic             ERR
);

   localparam int CNT_W = $clog2(MAX_OUT + 1);

   // ---------------------------------------------------------------- state
   logic [CNT_W-1:0]    r_cnt [K];
   logic [TAG_ID_W-1:0] r_ptr;
   logic                r_mul_start;
   logic [N-1:0]        r_mul_a;
   logic [N-1:0]        r_mul_b;
   logic [K-1:0]        r_res_valid;
   logic [2*N-1:0]      r_res_s;
   logic                r_err;

   // ---------------------------------------------------------------- wires
   logic [MAX_K-1:0]    w_elig;
   logic [MAX_K-1:0]    w_pick;
   logic                w_grant_ok;
   logic                w_gnt_any;
   logic [TAG_ID_W-1:0] w_gnt_id;
   logic [K-1:0]        w_gnt;
   logic [K-1:0]        w_inc;
   logic [N-1:0]        w_sel_a;
   logic [N-1:0]        w_sel_b;
   tag_t                w_tag_in;
   tag_t                w_tag_out;
   logic                w_tags_busy;
   logic                w_deliver;
   logic                w_misalign;
   logic [K-1:0]        w_res_onehot;

   // ------------------------------------------------------------ arbitration
   // NOTE: every always_comb output gets a default before any conditional
   // assignment so no path leaves it unassigned (which would infer a latch).
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < K; i++) begin
         w_elig[i] = REQ[i] && (r_cnt[i] < CNT_W'(MAX_OUT));
      end
   end

   assign w_pick = rr_pick(w_elig, r_ptr, K);

   // Grants are suppressed while RESET is asserted so GNT reads 0 in reset.
   assign w_grant_ok = ENABLE & RESET;

   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      for (int i = 0; i < MAX_K; i++) begin
         if (w_pick[i] && w_grant_ok) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = TAG_ID_W'(i);
         end
      end
   end

   assign w_gnt = w_grant_ok ? w_pick[K-1:0] : '0;
   assign GNT   = w_gnt;
   assign w_inc = w_gnt & REQ;

   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < K; i++) begin
         if (w_gnt[i]) begin
            w_sel_a = A_IN[i*N +: N];
            w_sel_b = B_IN[i*N +: N];
         end
      end
   end

   // ------------------------------------------------------------ issue stage
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_ptr       <= '0;
         r_mul_start <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
      end else if (w_gnt_any) begin
         r_ptr       <= (w_gnt_id == TAG_ID_W'(K - 1)) ? '0 : w_gnt_id + 1'b1;
         r_mul_start <= 1'b1;
         r_mul_a     <= w_sel_a;
         r_mul_b     <= w_sel_b;
      end else begin
         r_mul_start <= 1'b0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
      end
   end

   assign MUL_START = r_mul_start;
   assign MUL_A     = r_mul_a;
   assign MUL_B     = r_mul_b;

   // ------------------------------------------------------------ tag pipeline
   assign w_tag_in = '{valid: w_gnt_any, id: w_gnt_id};

   mult_arb_tagpipe #(
      .LAT    (LAT)
   ) u_tagpipe (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .i_tag  (w_tag_in),
      .o_tag  (w_tag_out),
      .o_busy (w_tags_busy)
   );

   // ------------------------------------------------------------ result return
   // A result is accepted only when the multiplier and the tag pipeline agree;
   // any disagreement is an alignment fault and delivers nothing.
   assign w_deliver  = MUL_END & w_tag_out.valid;
   assign w_misalign = MUL_END ^ w_tag_out.valid;

   always_comb begin
      w_res_onehot = '0;
      for (int i = 0; i < K; i++) begin
         w_res_onehot[i] = w_deliver && (w_tag_out.id == TAG_ID_W'(i));
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_res_valid <= '0;
         r_res_s     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_res_valid <= w_res_onehot;
         if (w_deliver) begin
            r_res_s <= MUL_S;
         end
         r_err <= r_err | w_misalign;
      end
   end

   assign RES_VALID = r_res_valid;
   assign RES_S     = r_res_s;
   assign ERR       = r_err;

   // ------------------------------------------------------------ outstanding
   // A grant and a return for the same requester in one cycle cancel out.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < K; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < K; i++) begin
            case ({w_inc[i], w_res_onehot[i]})
               2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
               2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
               default: r_cnt[i] <= r_cnt[i];
            endcase
         end
      end
   end

   // Stage 0 of the tag pipeline mirrors MUL_START, so the busy flag alone
   // already covers the issue cycle; MUL_START is kept for clarity.
   assign IDLE = ~r_mul_start & ~w_tags_busy;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arbiter
//   Self-checking bench: the arbiter drives a behavioural pipelined multiplier.
//   A transaction-level reference model (per-requester outstanding counts, a
//   queue of expected results stamped with their due edge) predicts every
//   output each cycle. Directed table vectors and hand-written sequences cover
//   latency, extremes, round-robin order, the outstanding limit, ENABLE,
//   reset mid-flight and the alignment error; a random phase follows.
// -----------------------------------------------------------------------------
module tb_mult_share_arbiter;

   localparam int N       = 8;
   localparam int K       = 4;
   localparam int LAT     = 10;
   localparam int MAX_OUT = 4;

   // ------------------------------------------------------------ DUT signals
   logic             clock;
   logic             reset_n;
   logic             enable;
   logic [K-1:0]     req;
   logic [K*N-1:0]   a_in;
   logic [K*N-1:0]   b_in;
   logic [K-1:0]     gnt;
   logic             mul_start;
   logic [N-1:0]     mul_a;
   logic [N-1:0]     mul_b;
   logic [2*N-1:0]   mul_s;
   logic             mul_end;
   logic [K-1:0]     res_valid;
   logic [2*N-1:0]   res_s;
   logic             idle;
   logic             err;
   logic             force_end;

   mult_share_arbiter #(
      .N         (N),
      .K         (K),
      .LAT       (LAT),
      .MAX_OUT   (MAX_OUT)
   ) dut (
      .CLOCK     (clock),
      .RESET     (reset_n),
      .ENABLE    (enable),
      .REQ       (req),
      .A_IN      (a_in),
      .B_IN      (b_in),
      .GNT       (gnt),
      .MUL_START (mul_start),
      .MUL_A     (mul_a),
      .MUL_B     (mul_b),
      .MUL_S     (mul_s),
      .MUL_END   (mul_end),
      .RES_VALID (res_valid),
      .RES_S     (res_s),
      .IDLE      (idle),
      .ERR       (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [2*N-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
      int pa;
      int pb;
      int p;
      pa = int'($signed(a));
      pb = int'($signed(b));
      p  = pa * pb;
      return p[2*N-1:0];
   endfunction

   // ------------------------------------------------ attached multiplier
   // Samples MUL_START/operands one edge after the grant and presents the
   // product LAT-1 edges later, i.e. in the cycle the last tag stage holds it.
   logic [LAT-2:0] mp_v;
   logic [2*N-1:0] mp_p [LAT-1];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mp_v <= '0;
         for (int j = 0; j < LAT - 1; j++) mp_p[j] <= '0;
      end else begin
         mp_v    <= {mp_v[LAT-3:0], mul_start};
         mp_p[0] <= smul(mul_a, mul_b);
         for (int j = 1; j < LAT - 1; j++) mp_p[j] <= mp_p[j-1];
      end
   end

   assign mul_end = mp_v[LAT-2] | force_end;
   assign mul_s   = mp_p[LAT-2];

   // ------------------------------------------------------------ checking
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   typedef struct {
      int             due;
      int             id;
      logic [2*N-1:0] prod;
   } pend_t;

   pend_t          pend [$];
   int             m_cnt [K];
   int             m_ptr;
   int             m_edge = 0;
   logic           m_start;
   logic [N-1:0]   m_a;
   logic [N-1:0]   m_b;
   logic [2*N-1:0] m_rs;
   logic           m_err;

   logic [K-1:0]   s_gnt;
   logic [K-1:0]   s_gexp;
   logic [K-1:0]   s_rv;
   logic [2*N-1:0] s_rs;
   logic           s_idle;
   logic           s_err;

   task automatic model_reset();
      pend.delete();
      for (int i = 0; i < K; i++) m_cnt[i] = 0;
      m_ptr   = 0;
      m_start = 1'b0;
      m_a     = '0;
      m_b     = '0;
      m_rs    = '0;
      m_err   = 1'b0;
   endtask

   function automatic int oh2idx(input logic [K-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < K; i++) if (v[i]) r = i;
      return r;
   endfunction

   // First eligible requester scanning circularly from the pointer.
   function automatic logic [K-1:0] model_gnt();
      logic [K-1:0] g;
      g = '0;
      if (!enable || !reset_n) return g;
      for (int off = 0; off < K; off++) begin
         int i;
         i = (m_ptr + off) % K;
         if (req[i] && m_cnt[i] < MAX_OUT) begin
            g[i] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
      a_in[i*N +: N] = a;
      b_in[i*N +: N] = b;
   endtask

   // One clock cycle: check the combinational grant, let the edge happen,
   // advance the model, then check every registered output at the negedge.
   task automatic step();
      logic [K-1:0] g;
      logic [K-1:0] erv;
      logic         delivered;
      int           gi;
      #1;
      g      = model_gnt();
      s_gnt  = gnt;
      s_gexp = g;
      check("gnt", 32'(gnt), 32'(g));
      @(posedge clock);
      m_edge++;
      erv       = '0;
      delivered = 1'b0;
      if (pend.size() > 0 && pend[0].due == m_edge) begin
         erv[pend[0].id] = 1'b1;
         m_rs = pend[0].prod;
         m_cnt[pend[0].id]--;
         void'(pend.pop_front());
         delivered = 1'b1;
      end
      if (force_end && !delivered) m_err = 1'b1;
      if (g != '0) begin
         gi = oh2idx(g);
         pend.push_back('{due: m_edge + LAT, id: gi, prod: smul(a_in[gi*N +: N], b_in[gi*N +: N])});
         m_cnt[gi]++;
         m_ptr   = (gi + 1) % K;
         m_start = 1'b1;
         m_a     = a_in[gi*N +: N];
         m_b     = b_in[gi*N +: N];
      end else begin
         m_start = 1'b0;
         m_a     = '0;
         m_b     = '0;
      end
      @(negedge clock);
      check("mul_start", 32'(mul_start), 32'(m_start));
      check("mul_a", 32'(mul_a), 32'(m_a));
      check("mul_b", 32'(mul_b), 32'(m_b));
      check("res_valid", 32'(res_valid), 32'(erv));
      check("res_s", 32'(res_s), 32'(m_rs));
      check("idle", 32'(idle), 32'(pend.size() == 0 && !m_start));
      check("err", 32'(err), 32'(m_err));
      s_rv   = res_valid;
      s_rs   = res_s;
      s_idle = idle;
      s_err  = err;
   endtask

   // Asserts reset asynchronously, checks reset values at once, releases
   // at a later negedge.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_mul_start", 32'(mul_start), 0);
      check("rst_mul_a", 32'(mul_a), 0);
      check("rst_mul_b", 32'(mul_b), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_s", 32'(res_s), 0);
      check("rst_idle", 32'(idle), 1);
      check("rst_err", 32'(err), 0);
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // ------------------------------------------------------------ directed table
   typedef struct {
      int             id;
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic [2*N-1:0] s;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int st;
      int cnt;
      logic seen;
      int got_id [$];
      int got_at [$];
      logic [2*N-1:0] got_s [$];
      int exp_rr_id [5];
      logic [2*N-1:0] exp_rr_s [5];
      logic [K-1:0] rr_gnt [5];
      logic [K-1:0] rr_req [5];

      vecs[0] = '{id: 0, a: 8'h03, b: 8'hFB, s: 16'hFFF1};   //    3 *   -5
      vecs[1] = '{id: 2, a: 8'h80, b: 8'h80, s: 16'h4000};   // -128 * -128
      vecs[2] = '{id: 2, a: 8'h7F, b: 8'h80, s: 16'hC080};   //  127 * -128
      vecs[3] = '{id: 3, a: 8'h7F, b: 8'h7F, s: 16'h3F01};   //  127 *  127
      vecs[4] = '{id: 1, a: 8'hF9, b: 8'h09, s: 16'hFFC1};   //   -7 *    9
      vecs[5] = '{id: 3, a: 8'hFF, b: 8'hFF, s: 16'h0001};   //   -1 *   -1

      exp_rr_id = '{0, 1, 2, 3, 0};
      exp_rr_s  = '{16'd0, 16'd2, 16'd6, 16'd12, 16'd0};
      rr_gnt    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_req    = '{4'hF, 4'hD, 4'h9, 4'h1, 4'h0};

      reset_n   = 1'b0;
      enable    = 1'b1;
      req       = '0;
      a_in      = '0;
      b_in      = '0;
      force_end = 1'b0;
      model_reset();
      @(negedge clock);
      do_reset();

      // ---- single operations: grant, LAT+1 edges (grant edge included), value
      for (int v = 0; v < 6; v++) begin
         req = '0;
         req[vecs[v].id] = 1'b1;
         set_op(vecs[v].id, vecs[v].a, vecs[v].b);
         step();
         check("tbl_gnt", 32'(s_gnt), 32'(1) << vecs[v].id);
         req  = '0;
         n    = 1;
         seen = 1'b0;
         while (!seen && n < 3 * LAT) begin
            step();
            n++;
            if (s_rv != '0) seen = 1'b1;
         end
         check("tbl_seen", 32'(seen), 1);
         check("tbl_latency", n, LAT + 1);
         check("tbl_rv", 32'(s_rv), 32'(1) << vecs[v].id);
         check("tbl_rs", 32'(s_rs), 32'(vecs[v].s));
         step();
         check("tbl_pulse", 32'(s_rv), 0);
         check("tbl_idle", 32'(s_idle), 1);
      end

      // ---- round robin: grants 0,1,2,3,0 then consecutive results
      do_reset();
      for (int i = 0; i < K; i++) set_op(i, N'(i), N'(i + 1));
      req = 4'hF;
      for (int s = 0; s < 5; s++) begin
         step();
         check("rr_gnt", 32'(s_gnt), 32'(rr_gnt[s]));
         req = rr_req[s];
      end
      st = 5;
      while (got_id.size() < 5 && st < 5 + 3 * LAT) begin
         step();
         st++;
         if (s_rv != '0) begin
            got_id.push_back(oh2idx(s_rv));
            got_s.push_back(s_rs);
            got_at.push_back(st);
         end
      end
      check("rr_count", got_id.size(), 5);
      for (int j = 0; j < got_id.size() && j < 5; j++) begin
         check("rr_id", got_id[j], exp_rr_id[j]);
         check("rr_val", 32'(got_s[j]), 32'(exp_rr_s[j]));
         if (j > 0) check("rr_consecutive", got_at[j], got_at[j-1] + 1);
      end

      // ---- outstanding limit on requester 1
      do_reset();
      set_op(1, 8'd5, 8'd6);
      req = 4'b0010;
      for (int s = 1; s <= LAT + 2; s++) begin
         step();
         check("lim_gnt", 32'(s_gnt), (s <= MAX_OUT || s == LAT + 2) ? 32'h2 : 32'h0);
         if (s == LAT + 1) check("lim_first_result", 32'(s_rv), 32'h2);
      end

      // ---- ENABLE dropped after three grants
      do_reset();
      req = '0;
      for (int i = 0; i < K; i++) set_op(i, N'(i + 2), N'(8'hF0 + i));
      req = 4'hF;
      for (int s = 0; s < 3; s++) begin
         step();
         req[s] = 1'b0;
      end
      enable = 1'b0;
      cnt = 0;
      for (int s = 0; s < LAT + 5; s++) begin
         step();
         if (s_rv != '0) cnt++;
      end
      check("en_results", cnt, 3);
      check("en_idle", 32'(s_idle), 1);

      // ---- reset mid-flight
      do_reset();
      req    = '0;
      enable = 1'b1;
      set_op(0, 8'h11, 8'h22);
      req = 4'b0001;
      for (int s = 0; s < 3; s++) step();
      req = '0;
      step();
      step();
      do_reset();
      cnt = 0;
      for (int s = 0; s < LAT + 4; s++) begin
         step();
         if (s_rv != '0) cnt++;
      end
      check("rst_no_results", cnt, 0);
      check("rst_err_clear", 32'(s_err), 0);

      // ---- alignment error: MUL_END with no tag in flight
      force_end = 1'b1;
      step();
      force_end = 1'b0;
      check("err_set", 32'(s_err), 1);
      check("err_no_result", 32'(s_rv), 0);
      for (int s = 0; s < 5; s++) step();
      check("err_sticky", 32'(s_err), 1);

      // ---- randomized traffic against the model
      do_reset();
      req = '0;
      for (int s = 0; s < 600; s++) begin
         step();
         for (int i = 0; i < K; i++) begin
            if (s_gexp[i]) begin
               req[i] = 1'($urandom_range(0, 1));
               if (req[i]) set_op(i, N'($urandom), N'($urandom));
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               set_op(i, N'($urandom), N'($urandom));
            end
         end
         enable = ($urandom_range(0, 7) != 0);
      end
      // Let outstanding requests be granted, then drain.
      enable = 1'b1;
      for (int s = 0; s < 4 * K && req != '0; s++) begin
         step();
         req = req & ~s_gexp;
      end
      for (int s = 0; s < LAT + 3; s++) step();
      check("rnd_final_idle", 32'(s_idle), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
